// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, reset/bubble constants and the
// IF/ID pipeline record handed from fetch to decode.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int ROM_ADDR_W = 10;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } if_id_t;

  // Redirect targets are byte addresses; fetch only ever runs word-aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: ROM address/data, decode-side control (stall/redirect)
// and the IF/ID outputs plus PC and delivered-instruction counter.
interface fetch_unit_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              stall;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              if_id_valid;
  logic [DATA_W-1:0] if_id_instr;
  logic [31:0]       if_id_pc;
  logic [31:0]       pc;
  logic [31:0]       fetch_count;

  // Fetch unit side.
  modport master (
    output rom_addr,
    input  rom_data,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    output if_id_valid,
    output if_id_instr,
    output if_id_pc,
    output pc,
    output fetch_count
  );

  // ROM / decode side.
  modport slave (
    input  rom_addr,
    output rom_data,
    output stall,
    output redirect_valid,
    output redirect_pc,
    input  if_id_valid,
    input  if_id_instr,
    input  if_id_pc,
    input  pc,
    input  fetch_count
  );

endinterface

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register. Reset and flush both load a bubble; otherwise the
// register loads the fetched record or holds it.
module if_id_reg #(
  parameter logic [31:0] FLUSH_INSTR = 32'h0000_0013
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            load,
  input  logic            flush,
  input  cpu_pkg::if_id_t d,
  output cpu_pkg::if_id_t q
);
  import cpu_pkg::*;

  if_id_t q_reg;

  // Bubble on reset/flush, capture on load, otherwise hold.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      q_reg.valid <= 1'b0;
      q_reg.instr <= FLUSH_INSTR;
      q_reg.pc    <= '0;
    end else if (load) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses the asynchronous-read
// instruction ROM straight from the PC and captures the returned word into
// IF/ID. Priority per edge: reset > redirect > stall > normal advance.
module fetch_unit #(
  parameter int          ADDR_W    = 10,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic         CLK,
  input  logic         RST,
  fetch_unit_if.master bus
);
  import cpu_pkg::*;

  logic [31:0] pc_reg;
  logic [31:0] pc_next;
  logic [31:0] count_reg;
  logic [31:0] count_next;
  logic        load;
  logic        flush;
  if_id_t      fetched;
  if_id_t      if_id_q;

  // The ROM sees the PC directly; upper PC bits alias (ROM wraps silently).
  assign bus.rom_addr = pc_reg[ADDR_W+1:2];

  // A redirect flushes IF/ID even when decode is stalled.
  assign flush = bus.redirect_valid;
  assign load  = !bus.redirect_valid && !bus.stall;

  // Next PC and delivered-instruction count.
  always_comb begin
    pc_next    = pc_reg;
    count_next = count_reg;
    if (bus.redirect_valid) begin
      pc_next = align_word(bus.redirect_pc);
    end else if (!bus.stall) begin
      pc_next    = pc_reg + 32'd4;
      count_next = count_reg + 32'd1;
    end
  end

  // PC and counter state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_reg    <= RESET_PC;
      count_reg <= '0;
    end else begin
      pc_reg    <= pc_next;
      count_reg <= count_next;
    end
  end

  assign fetched.valid = 1'b1;
  assign fetched.instr = bus.rom_data;
  assign fetched.pc    = pc_reg;

  if_id_reg #(
    .FLUSH_INSTR(NOP_INSTR)
  ) u_if_id (
    .CLK  (CLK),
    .RST  (RST),
    .load (load),
    .flush(flush),
    .d    (fetched),
    .q    (if_id_q)
  );

  assign bus.if_id_valid = if_id_q.valid;
  assign bus.if_id_instr = if_id_q.instr;
  assign bus.if_id_pc    = if_id_q.pc;
  assign bus.pc          = pc_reg;
  assign bus.fetch_count = count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural async-read ROM and a
// scoreboard of expected IF/ID records.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK;
  logic        RST;
  logic [31:0] mem [1024];

  int tests = 0;
  int fails = 0;

  // Reference model state.
  logic [31:0] pc_m;
  logic [31:0] cnt_m;
  if_id_t      cur_m;
  if_id_t      sb [$];

  fetch_unit_if bus ();

  fetch_unit dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  assign bus.rom_data = mem[bus.rom_addr];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Predict the edge from current inputs, clock it, then compare.
  task automatic step();
    if_id_t      e;
    logic [31:0] pc_n;
    logic [31:0] cnt_n;
    pc_n  = pc_m;
    cnt_n = cnt_m;
    if (RST) begin
      e     = '{valid: 1'b0, instr: NOP, pc: 32'h0};
      pc_n  = 32'h0;
      cnt_n = 32'h0;
    end else if (bus.redirect_valid) begin
      e    = '{valid: 1'b0, instr: NOP, pc: 32'h0};
      pc_n = {bus.redirect_pc[31:2], 2'b00};
    end else if (bus.stall) begin
      e = cur_m;
    end else begin
      e     = '{valid: 1'b1, instr: mem[pc_m[11:2]], pc: pc_m};
      pc_n  = pc_m + 32'd4;
      cnt_n = cnt_m + 32'd1;
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    pc_m  = pc_n;
    cnt_m = cnt_n;
    cur_m = sb.pop_front();
    check("if_id_valid", {31'b0, bus.if_id_valid}, {31'b0, cur_m.valid});
    check("if_id_instr", bus.if_id_instr, cur_m.instr);
    check("if_id_pc", bus.if_id_pc, cur_m.pc);
    check("pc", bus.pc, pc_m);
    check("fetch_count", bus.fetch_count, cnt_m);
    check("rom_addr", {22'b0, bus.rom_addr}, {22'b0, pc_m[11:2]});
    if (bus.if_id_valid === 1'b1) begin
      tests++;
      assert (bus.if_id_instr === mem[bus.if_id_pc[11:2]]) else begin
        fails++;
        $error("FAIL golden_rom: observed %h expected %h at pc %h",
               bus.if_id_instr, mem[bus.if_id_pc[11:2]], bus.if_id_pc);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "golden ROM check aborted the run");
      end
    end
    $display("[TB] cyc pc=%h rom_addr=%0d if_id v=%0b pc=%h instr=%h cnt=%0d",
             bus.pc, bus.rom_addr, bus.if_id_valid, bus.if_id_pc, bus.if_id_instr,
             bus.fetch_count);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = (i * 32'h9E37_79B1) ^ 32'h0000_5A13;
    end
    pc_m  = 32'h0;
    cnt_m = 32'h0;
    cur_m = '{valid: 1'b0, instr: NOP, pc: 32'h0};
    RST   = 1'b1;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;

    // 1. Reset then free-run.
    step();
    step();
    RST = 1'b0;
    check("t1_rom_addr0", {22'b0, bus.rom_addr}, 32'd0);
    check("t1_valid0", {31'b0, bus.if_id_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t1_rom_addr", {22'b0, bus.rom_addr}, i + 1);
      check("t1_if_id_pc", bus.if_id_pc, i * 4);
    end
    check("t1_count", bus.fetch_count, 32'd4);
    check("t1_pc", bus.pc, 32'h10);

    // 2. Stall three cycles.
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("t2_pc_held", bus.pc, 32'h10);
    check("t2_rom_addr_held", {22'b0, bus.rom_addr}, 32'd4);
    check("t2_if_id_pc_held", bus.if_id_pc, 32'hC);
    check("t2_count_held", bus.fetch_count, 32'd4);
    bus.stall = 1'b0;
    step();
    check("t2_if_id_pc", bus.if_id_pc, 32'h10);
    check("t2_instr", bus.if_id_instr, mem[4]);

    // 3. Redirect to 0x40.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h40;
    step();
    check("t3_bubble_valid", {31'b0, bus.if_id_valid}, 32'd0);
    check("t3_bubble_instr", bus.if_id_instr, NOP);
    check("t3_pc", bus.pc, 32'h40);
    bus.redirect_valid = 1'b0;
    step();
    check("t3_if_id_pc", bus.if_id_pc, 32'h40);
    check("t3_instr", bus.if_id_instr, mem[16]);

    // 4. Redirect beats stall, low target bits dropped.
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h23;
    step();
    check("t4_pc", bus.pc, 32'h20);
    check("t4_bubble", {31'b0, bus.if_id_valid}, 32'd0);
    check("t4_count", bus.fetch_count, 32'd6);
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    step();

    // 5. ROM address wrap.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFC;
    step();
    check("t5_rom_addr_top", {22'b0, bus.rom_addr}, 32'd1023);
    bus.redirect_valid = 1'b0;
    step();
    check("t5_rom_addr_wrap", {22'b0, bus.rom_addr}, 32'd0);
    check("t5_pc", bus.pc, 32'h1000);
    check("t5_if_id_pc", bus.if_id_pc, 32'hFFC);
    check("t5_instr", bus.if_id_instr, mem[1023]);

    // 5b. Full 32-bit PC wrap.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    step();
    bus.redirect_valid = 1'b0;
    step();
    check("t5b_pc_wrap", bus.pc, 32'h0);
    check("t5b_if_id_pc", bus.if_id_pc, 32'hFFFF_FFFC);
    step();

    // 6. Reset overrides stall and redirect.
    bus.stall          = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h80;
    RST                = 1'b1;
    step();
    check("t6_pc", bus.pc, 32'h0);
    check("t6_valid", {31'b0, bus.if_id_valid}, 32'd0);
    check("t6_instr", bus.if_id_instr, NOP);
    check("t6_count", bus.fetch_count, 32'd0);
    RST                = 1'b0;
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    step();
    check("t6_restart_count", bus.fetch_count, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
